seq_pattern_gen: RTL and testbench
==================================

// Module: seq_pattern_gen
// PURPOSE
//   Serial transmitter for programmable WIDTH-bit bit sequences: the source side of the
//   sequence-detector path. On start it latches a pattern, repeat count and inter-frame gap,
//   then drives the pattern MSB-first on dout with a valid/ready handshake. Left-padded zeros
//   are part of the frame (WIDTH=5, pattern 'b11 sends 0,0,0,1,1). Feeds detector benches/links.
// PARAMETERS
//   WIDTH  5  pattern length in bits (>=2)
//   RPT_W  4  width of repeat_cnt; frames sent = repeat_cnt+1
//   GAP_W  3  width of gap; idle cycles inserted between consecutive frames
// PORTS
//   clk         in   1        clock, all state on posedge
//   resetn      in   1        asynchronous active-low reset
//   start       in   1        request; accepted only when busy==0
//   pattern     in   WIDTH    frame bits, latched on accepted start
//   repeat_cnt  in   RPT_W    extra frames, latched on accepted start
//   gap         in   GAP_W    gap cycles between frames, latched on accepted start
//   abort       in   1        synchronous cancel of current transmission
//   dout_ready  in   1        downstream accepts dout this cycle
//   dout        out  1        serial data bit
//   dout_valid  out  1        dout carries a frame bit
//   busy        out  1        transmission in progress
//   done        out  1        one-cycle pulse after final bit of final frame transfers
// BEHAVIOUR
//   - Reset (resetn=0, async): state IDLE; dout=0, dout_valid=0, busy=0, done=0 immediately.
//   - All outputs registered. Transfer = dout_valid && dout_ready at a posedge.
//   - FSM states IDLE, SEND, GAP:
//     IDLE: start=1 latches inputs -> SEND; next cycle dout=pattern[WIDTH-1], valid=1, busy=1.
//     SEND: on transfer advance bit index MSB->LSB; dout_ready=0 holds dout and index.
//       Last bit transferred, frames remaining>0: gap==0 -> SEND bit WIDTH-1 next cycle
//       (back-to-back); gap>0 -> GAP. Frames remaining==0 -> IDLE, done=1 next cycle.
//     GAP: dout=0, valid=0, busy=1 for exactly gap cycles (counts regardless of dout_ready),
//       then SEND from bit WIDTH-1.
//   - done and busy-fall occur in the same cycle; start in that cycle is accepted.
//   - start while busy=1: ignored, latched values unchanged.
//   - abort=1 in SEND/GAP: next cycle IDLE, valid=0, busy=0, no done pulse; abort has
//     priority over a coincident transfer. abort in IDLE ignored; abort+start in IDLE: start wins.
//   - Repeat counter: RPT_W-bit down-counter, no wrap; repeat_cnt=all-ones sends 2^RPT_W frames.
//   - Input changes on pattern/repeat_cnt/gap while busy have no effect.
//   - Async reset mid-frame: abandons frame, no done, outputs zero within the same cycle.
// TESTING
//   1. pattern=01011, rpt=0, gap=0, ready=1, start@c0 -> dout 0,1,0,1,1 c1-c5, valid c1-c5, done c6.
//   2. pattern=00011 (padding), rpt=2, gap=0 -> 15 contiguous valid bits c1-c15, done c16 only.
//   3. pattern=10110, rpt=1, gap=3 -> frame c1-c5, valid=0 c6-c8, frame c9-c13, done c14.
//   4. Test 1 with ready=0 c2-c3 -> dout holds 1 c2-c4, remaining bits c5-c7, done c8.
//   5. start@c2 while busy ignored; abort@c3 -> c4 IDLE, busy=0, no done; start@c4 accepted.
//   6. resetn low mid-frame -> outputs 0 same cycle; loopback to detector with init=pattern
//      after clean start -> detector pulses once per frame, never on partial/aborted frames.

Source files
------------

// File: rtl/seq_pattern_gen.sv
// rtl/seq_pattern_gen.sv - serial MSB-first pattern transmitter with repeat, gap and valid/ready
module seq_pattern_gen #(
    parameter int WIDTH = 5,
    parameter int RPT_W = 4,
    parameter int GAP_W = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [RPT_W-1:0] repeat_cnt,
    input  logic [GAP_W-1:0] gap,
    input  logic             abort,
    input  logic             dout_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);

    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] MSB_IDX = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] pat_q;
    logic [RPT_W-1:0] rem_q;
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gcnt_q;
    logic [IW-1:0]    idx_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            pat_q      <= '0;
            rem_q      <= '0;
            gap_q      <= '0;
            gcnt_q     <= '0;
            idx_q      <= '0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // abort is meaningless here, so a coincident start always wins
                    if (start) begin
                        pat_q      <= pattern;
                        rem_q      <= repeat_cnt;
                        gap_q      <= gap;
                        idx_q      <= MSB_IDX;
                        dout       <= pattern[WIDTH-1];
                        dout_valid <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (abort) begin
                        state      <= ST_IDLE;
                        dout       <= 1'b0;
                        dout_valid <= 1'b0;
                        busy       <= 1'b0;
                    end else if (dout_ready) begin
                        if (idx_q != '0) begin
                            idx_q <= idx_q - 1'b1;
                            dout  <= pat_q[idx_q - 1'b1];
                        end else if (rem_q != '0) begin
                            rem_q <= rem_q - 1'b1;
                            idx_q <= MSB_IDX;
                            if (gap_q == '0) begin
                                dout <= pat_q[WIDTH-1];
                            end else begin
                                state      <= ST_GAP;
                                gcnt_q     <= gap_q;
                                dout       <= 1'b0;
                                dout_valid <= 1'b0;
                            end
                        end else begin
                            state      <= ST_IDLE;
                            dout       <= 1'b0;
                            dout_valid <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    // idle cycles elapse whether or not the sink is ready
                    if (abort) begin
                        state      <= ST_IDLE;
                        dout       <= 1'b0;
                        dout_valid <= 1'b0;
                        busy       <= 1'b0;
                    end else if (gcnt_q == GAP_W'(1)) begin
                        state      <= ST_SEND;
                        dout       <= pat_q[WIDTH-1];
                        dout_valid <= 1'b1;
                    end else begin
                        gcnt_q <= gcnt_q - 1'b1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    dout       <= 1'b0;
                    dout_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb/tb_seq_pattern_gen.sv - self-checking bench for seq_pattern_gen
module tb_seq_pattern_gen;

    localparam int W = 5;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic [4:0] pattern;
    logic [3:0] repeat_cnt;
    logic [2:0] gap;
    logic       abort;
    logic       dout_ready;
    logic       dout;
    logic       dout_valid;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    seq_pattern_gen #(.WIDTH(5), .RPT_W(4), .GAP_W(3)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .pattern    (pattern),
        .repeat_cnt (repeat_cnt),
        .gap        (gap),
        .abort      (abort),
        .dout_ready (dout_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Reference: the whole transmission is a queue of items (0/1 = frame bit, 2 = idle gap slot)
    int   q[$];
    logic m_done;

    typedef struct {
        logic       s;
        logic [4:0] p;
        logic [3:0] r;
        logic [2:0] g;
        logic       rdy;
        logic       ab;
        logic       ed;
        logic       ev;
        logic       eb;
        logic       edn;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic s, input logic [4:0] p, input logic [3:0] r,
                              input logic [2:0] g, input logic rdy, input logic ab);
        m_done = 1'b0;
        if (q.size() != 0) begin
            if (ab) begin
                q.delete();
            end else if (q[0] == 2 || rdy) begin
                void'(q.pop_front());
                if (q.size() == 0) m_done = 1'b1;
            end
        end else if (s) begin
            for (int f = 0; f <= int'(r); f++) begin
                for (int b = W - 1; b >= 0; b--) q.push_back(int'(p[b]));
                if (f < int'(r)) for (int k = 0; k < int'(g); k++) q.push_back(2);
            end
        end
    endtask

    task automatic cyc(input logic s, input logic [4:0] p, input logic [3:0] r,
                       input logic [2:0] g, input logic rdy, input logic ab);
        logic ev;
        logic ed;
        start = s; pattern = p; repeat_cnt = r; gap = g; dout_ready = rdy; abort = ab;
        @(posedge clk);
        model_step(s, p, r, g, rdy, ab);
        #1;
        ev = (q.size() != 0) && (q[0] != 2);
        ed = ev && (q[0] == 1);
        chk("m_valid", {31'd0, dout_valid}, {31'd0, ev});
        chk("m_dout",  {31'd0, dout},       {31'd0, ed});
        chk("m_busy",  {31'd0, busy},       {31'd0, q.size() != 0});
        chk("m_done",  {31'd0, done},       {31'd0, m_done});
    endtask

    int   nvalid;
    int   ndone;
    int   done_cyc;
    logic [31:0] vmap;

    // Runs ready=1 idle-input cycles from cycle 2 onward until busy drops; cycle numbers relative to start
    task automatic drain(input string nm);
        int c;
        c = 2;
        while (busy && c < 400) begin
            cyc(1'b0, 5'd0, 4'd0, 3'd0, 1'b1, 1'b0);
            if (dout_valid) begin
                nvalid++;
                if (c < 32) vmap[c] = 1'b1;
            end
            if (done) begin
                ndone++;
                done_cyc = c;
            end
            c++;
        end
        if (busy) chk({nm, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic launch(input logic [4:0] p, input logic [3:0] r, input logic [2:0] g);
        nvalid = 0; ndone = 0; done_cyc = -1; vmap = '0;
        cyc(1'b1, p, r, g, 1'b1, 1'b0);
        if (dout_valid) begin
            nvalid++;
            vmap[1] = 1'b1;
        end
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; pattern = '0; repeat_cnt = '0; gap = '0;
        abort = 1'b0; dout_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout",  {31'd0, dout},       32'd0);
        chk("rst_valid", {31'd0, dout_valid}, 32'd0);
        chk("rst_busy",  {31'd0, busy},       32'd0);
        chk("rst_done",  {31'd0, done},       32'd0);
        resetn = 1'b1;

        // single frame, then the same frame with a two-cycle backpressure stall
        tbl[0]  = '{1'b1, 5'b01011, 4'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 5'b00000, 4'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 5'b00000, 4'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 5'b00000, 4'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 5'b00000, 4'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 5'b00000, 4'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 5'b00000, 4'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 5'b01011, 4'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 5'b00000, 4'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 5'b00000, 4'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 5'b00000, 4'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 5'b00000, 4'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 5'b00000, 4'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 5'b00000, 4'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 5'b00000, 4'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 5'b00000, 4'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 16; i++) begin
            cyc(tbl[i].s, tbl[i].p, tbl[i].r, tbl[i].g, tbl[i].rdy, tbl[i].ab);
            chk($sformatf("tbl%0d_dout", i),  {31'd0, dout},       {31'd0, tbl[i].ed});
            chk($sformatf("tbl%0d_valid", i), {31'd0, dout_valid}, {31'd0, tbl[i].ev});
            chk($sformatf("tbl%0d_busy", i),  {31'd0, busy},       {31'd0, tbl[i].eb});
            chk($sformatf("tbl%0d_done", i),  {31'd0, done},       {31'd0, tbl[i].edn});
        end

        // three back-to-back padded frames
        launch(5'b00011, 4'd2, 3'd0);
        drain("t2");
        chk("t2_valid_cnt", nvalid, 32'd15);
        chk("t2_valid_map", vmap, 32'h0000_FFFE);
        chk("t2_done_cyc", done_cyc, 32'd16);
        chk("t2_done_cnt", ndone, 32'd1);

        // two frames separated by a 3-cycle gap
        launch(5'b10110, 4'd1, 3'd3);
        drain("t3");
        chk("t3_valid_map", vmap, 32'h0000_3E3E);
        chk("t3_done_cyc", done_cyc, 32'd14);

        // start while busy ignored, abort, immediate restart
        cyc(1'b1, 5'b01011, 4'd0, 3'd0, 1'b1, 1'b0);
        cyc(1'b0, 5'b00000, 4'd0, 3'd0, 1'b1, 1'b0);
        cyc(1'b1, 5'b10000, 4'd5, 3'd7, 1'b1, 1'b0);
        chk("t5_ignored_dout", {31'd0, dout}, 32'd0);
        cyc(1'b0, 5'b00000, 4'd0, 3'd0, 1'b1, 1'b1);
        chk("t5_abort_busy", {31'd0, busy}, 32'd0);
        chk("t5_abort_done", {31'd0, done}, 32'd0);
        nvalid = 0; ndone = 0; done_cyc = -1; vmap = '0;
        cyc(1'b1, 5'b11100, 4'd0, 3'd0, 1'b1, 1'b0);
        chk("t5_restart_dout", {31'd0, dout}, 32'd1);
        chk("t5_restart_busy", {31'd0, busy}, 32'd1);
        drain("t5");
        chk("t5_done_cnt", ndone, 32'd1);

        // all-ones repeat count sends 2^RPT_W frames
        launch(5'b10101, 4'd15, 3'd0);
        drain("t_rmax");
        chk("rmax_bits", nvalid, 32'd80);
        chk("rmax_done", ndone, 32'd1);

        // asynchronous reset in mid-frame
        cyc(1'b1, 5'b11111, 4'd3, 3'd2, 1'b1, 1'b0);
        cyc(1'b0, 5'b00000, 4'd0, 3'd0, 1'b1, 1'b0);
        #2 resetn = 1'b0;
        #1;
        chk("arst_dout",  {31'd0, dout},       32'd0);
        chk("arst_valid", {31'd0, dout_valid}, 32'd0);
        chk("arst_busy",  {31'd0, busy},       32'd0);
        chk("arst_done",  {31'd0, done},       32'd0);
        q.delete();
        @(negedge clk);
        resetn = 1'b1;
        cyc(1'b0, 5'b00000, 4'd0, 3'd0, 1'b1, 1'b0);

        // randomized traffic against the queue model
        for (int i = 0; i < 1500; i++) begin
            logic       s;
            logic [4:0] p;
            logic [3:0] r;
            logic [2:0] g;
            logic       rdy;
            logic       ab;
            s   = ($urandom % 4) == 0;
            p   = 5'($urandom);
            r   = (($urandom % 8) == 0) ? 4'd15 : 4'($urandom % 3);
            g   = 3'($urandom % 8);
            rdy = ($urandom % 4) != 0;
            ab  = ($urandom % 40) == 0;
            cyc(s, p, r, g, rdy, ab);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
